// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder cell processes one operand bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.

module full_adder (
    output logic s,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic c
);

    // Single-bit sum and carry
    always_comb begin
        s    = a ^ b ^ c;
        cout = (a & b) | (c & (a ^ b));
    end

endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             fa_s;
    logic             fa_cout;
    logic             last_bit_s;

    full_adder u_fa (
        .s    (fa_s),
        .cout (fa_cout),
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .c    (carry_q)
    );

    assign last_bit_s = (cnt_q == CW'(WIDTH - 1));

    // Next-state, datapath and output decode
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    res_d   = {WIDTH{1'b0}};
                    cnt_d   = {CW{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // LSB-first operands, result bits enter at the MSB end
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = fa_cout;
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                if (last_bit_s) begin
                    cnt_d   = {CW{1'b0}};
                    sum_d   = {fa_s, res_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = carry_q ^ fa_cout;
`endif
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= {WIDTH{1'b0}};
            b_sh_q  <= {WIDTH{1'b0}};
            res_q   <= {WIDTH{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign busy = busy_q;
    assign done = done_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random self-checking bench for serial_adder (WIDTH=8).
// Define SERIAL_ADDER_OVF_EN to also check the overflow output.

module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       busy;
    logic       done;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf;
`endif

    int n_checks;
    int n_fail;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic get_ovf();
`ifdef SERIAL_ADDER_OVF_EN
        return ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Start one addition, scramble operands after acceptance, wait for done
    task automatic run_op(input logic [7:0] a_v, input logic [7:0] b_v, input logic cin_v,
                          output logic [7:0] s, output logic co, output logic ov, output int lat);
        @(negedge clk);
        a = a_v; b = b_v; cin = cin_v; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = ~a_v; b = a_v ^ b_v; cin = ~cin_v;
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        s = sum; co = cout; ov = get_ovf();
    endtask

    task automatic test_reset();
        logic [7:0] s; logic co, ov; int lat;
        #2;
        n_checks++;
        if ({sum, cout, busy, done, get_ovf()} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got sum=%h cout=%b busy=%b done=%b ovf=%b, want all 0",
                     sum, cout, busy, done, get_ovf());
        end
        // start held through reset release is taken on the first clock
        @(negedge clk);
        a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_accept: busy=%b want 1", busy);
        end
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        s = sum; co = cout; ov = get_ovf();
        n_checks++;
        if (lat !== 8 || s !== 8'h33 || co !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_result: lat=%0d sum=%h cout=%b want lat=8 sum=33 cout=0", lat, s, co);
        end
    endtask

    task automatic test_basic();
        int lat;
        @(negedge clk);
        a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy: busy=%b done=%b want busy=1 done=0", busy, done);
        end
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d edges want 8", lat);
        end
        n_checks++;
        if (sum !== 8'h96 || cout !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: sum=%h cout=%b busy=%b want sum=96 cout=0 busy=0", sum, cout, busy);
        end
`ifdef SERIAL_ADDER_OVF_EN
        n_checks++;
        if (ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_ovf: got %b want 1", ovf);
        end
`endif
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sum !== 8'h96) begin
            n_fail++;
            $display("FAIL basic_done_pulse: done=%b busy=%b sum=%h want done=0 busy=0 sum=96", done, busy, sum);
        end
    endtask

    task automatic test_carry();
        logic [7:0] s; logic co, ov; int lat;
        run_op(8'hFF, 8'h01, 1'b0, s, co, ov, lat);
        n_checks++;
        if (s !== 8'h00 || co !== 1'b1 || lat !== 8) begin
            n_fail++;
            $display("FAIL carry_ff_01: sum=%h cout=%b lat=%0d want sum=00 cout=1 lat=8", s, co, lat);
        end
`ifdef SERIAL_ADDER_OVF_EN
        n_checks++;
        if (ov !== 1'b0) begin
            n_fail++;
            $display("FAIL carry_ff_01_ovf: got %b want 0", ov);
        end
`endif
        run_op(8'hFF, 8'hFF, 1'b1, s, co, ov, lat);
        n_checks++;
        if (s !== 8'hFF || co !== 1'b1 || lat !== 8) begin
            n_fail++;
            $display("FAIL carry_ff_ff_1: sum=%h cout=%b lat=%0d want sum=ff cout=1 lat=8", s, co, lat);
        end
`ifdef SERIAL_ADDER_OVF_EN
        n_checks++;
        if (ov !== 1'b0) begin
            n_fail++;
            $display("FAIL carry_ff_ff_1_ovf: got %b want 0", ov);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int n_done, c1, c2;
        logic [7:0] s1, s2; logic co1, co2, ov1, ov2;
        n_done = 0; c1 = 0; c2 = 0; s1 = 8'h00; s2 = 8'h00;
        co1 = 1'b0; co2 = 1'b0; ov1 = 1'b0; ov2 = 1'b0;
        @(negedge clk);
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 8'h80; b = 8'h80;
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                n_done++;
                if (n_done == 1) begin
                    c1 = c; s1 = sum; co1 = cout; ov1 = get_ovf();
                end else begin
                    c2 = c; s2 = sum; co2 = cout; ov2 = get_ovf();
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        n_checks++;
        if (n_done !== 2 || c1 !== 8 || c2 - c1 !== 9) begin
            n_fail++;
            $display("FAIL b2b_timing: dones=%0d first=%0d second=%0d want 2 at 8 and 17", n_done, c1, c2);
        end
        n_checks++;
        if (s1 !== 8'h02 || co1 !== 1'b0 || s2 !== 8'h00 || co2 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_results: %h/%b then %h/%b want 02/0 then 00/1", s1, co1, s2, co2);
        end
`ifdef SERIAL_ADDER_OVF_EN
        n_checks++;
        if (ov1 !== 1'b0 || ov2 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ovf: %b then %b want 0 then 1", ov1, ov2);
        end
`endif
    endtask

    task automatic test_ignore_start();
        int n_done, c1;
        logic [7:0] prev, mid;
        prev = sum; n_done = 0; c1 = 0; mid = 8'h00;
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
            if (c == 3) begin
                mid = sum;
                a = 8'h00; b = 8'h00; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                n_done++;
                c1 = c;
            end
        end
        n_checks++;
        if (mid !== prev) begin
            n_fail++;
            $display("FAIL hold_during_run: sum=%h want %h", mid, prev);
        end
        n_checks++;
        if (n_done !== 1 || c1 !== 8 || sum !== 8'h30 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_start: dones=%0d at %0d sum=%h cout=%b want 1 at 8 sum=30 cout=0",
                     n_done, c1, sum, cout);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] s; logic co, ov; int lat, n_done;
        @(negedge clk);
        a = 8'h7F; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        n_checks++;
        if (sum !== 8'h30 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_hold: sum=%h busy=%b want sum=30 busy=1", sum, busy);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({sum, cout, busy, done, get_ovf()} !== 12'h000) begin
            n_fail++;
            $display("FAIL async_reset: sum=%h cout=%b busy=%b done=%b ovf=%b want all 0",
                     sum, cout, busy, done, get_ovf());
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) n_done++;
        end
        n_checks++;
        if (n_done !== 0) begin
            n_fail++;
            $display("FAIL reset_abandon: %0d cycles with done/busy after reset want 0", n_done);
        end
        run_op(8'h03, 8'h04, 1'b0, s, co, ov, lat);
        n_checks++;
        if (s !== 8'h07 || co !== 1'b0 || lat !== 8) begin
            n_fail++;
            $display("FAIL post_reset_add: sum=%h cout=%b lat=%0d want sum=07 cout=0 lat=8", s, co, lat);
        end
    endtask

    task automatic test_random();
        logic [7:0] s, av, bv, es; logic co, ov, cv, eo; logic [8:0] ref9; int lat;
        for (int i = 0; i < 1000; i++) begin
            av = 8'($urandom_range(255));
            bv = 8'($urandom_range(255));
            cv = 1'($urandom_range(1));
            ref9 = {1'b0, av} + {1'b0, bv} + {8'h00, cv};
            es = ref9[7:0];
            eo = (av[7] == bv[7]) && (es[7] != av[7]);
            run_op(av, bv, cv, s, co, ov, lat);
            n_checks++;
            if (s !== es || co !== ref9[8] || lat !== 8) begin
                n_fail++;
                $display("FAIL random_%0d: %h+%h+%b got sum=%h cout=%b lat=%0d want sum=%h cout=%b lat=8",
                         i, av, bv, cv, s, co, lat, es, ref9[8]);
            end
`ifdef SERIAL_ADDER_OVF_EN
            n_checks++;
            if (ov !== eo) begin
                n_fail++;
                $display("FAIL random_ovf_%0d: %h+%h+%b got %b want %b", i, av, bv, cv, ov, eo);
            end
`endif
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 1'b1;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        cin = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_ignore_start();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled on rising clk.
REQ-005 SHALL have port a  input  WIDTH  operand A, captured when start is accepted.
REQ-006 SHALL have port b  input  WIDTH  operand B, captured when start is accepted.
REQ-007 SHALL have port cin  input  1  carry-in, captured when start is accepted.
REQ-008 SHALL have port sum  output  WIDTH  registered result of a+b+cin (low WIDTH bits).
REQ-009 SHALL have port cout  output  1  registered carry-out of the addition.
REQ-010 SHALL have port busy  output  1  high while bits are being processed.
REQ-011 SHALL have port done  output  1  single-cycle pulse marking valid new result.
REQ-012 SHALL have port ovf  output  1  signed overflow flag, present only when SERIAL_ADDER_OVF_EN is defined.

Function
REQ-013 SHALL compute each bit with one instance of the existing full_adder module (port order s, cout, a, b, c); no multi-bit adder operator on operands.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-015 IDLE: start=1 -> latch a, b, cin into shift/carry registers, clear bit counter, go RUN; start=0 -> stay IDLE.
REQ-016 RUN: each edge feeds operand LSBs plus carry register to full_adder, shifts s into internal result shift register (MSB-first entry), stores full_adder cout into carry register, shifts operands right, increments counter.
REQ-017 RUN: edge processing bit WIDTH-1 -> copy completed shift register to sum, final carry to cout, go DONE.
REQ-018 DONE: done=1 for exactly this one cycle; next edge -> RUN with new operands latched if start=1, else IDLE.
REQ-019 Latency: start sampled at edge k -> sum/cout updated and done=1 after edge k+WIDTH; throughput one result per WIDTH+1 cycles with back-to-back start.
REQ-020 busy SHALL be 1 exactly in RUN; done exactly in DONE.
REQ-021 start while in RUN SHALL be ignored; operands and progress unaffected.
REQ-022 sum/cout (and ovf) SHALL hold the last completed result through IDLE and RUN until the next completion; partial results never appear on sum.
REQ-023 a, b, cin changes after acceptance SHALL not affect the result in progress.
REQ-024 Bit counter SHALL be ceil(log2(WIDTH)) bits minimum and not wrap before WIDTH-1 terminal check.

Reset
REQ-025 rst=1 SHALL immediately (no clock) force state IDLE, sum=0, cout=0, busy=0, done=0, ovf=0, counter/carry/shift registers=0.
REQ-026 rst asserted mid-RUN SHALL abandon the operation; no done pulse follows; first start after rst release begins a fresh addition.
REQ-027 start held high during rst release edge SHALL be accepted on the first rising clk with rst=0.

Configuration
REQ-028 Macro SERIAL_ADDER_OVF_EN: defined -> ovf port exists, updated at completion with (carry into MSB) XOR (carry out of MSB), held like sum; undefined -> ovf port and its logic absent, all else identical.

Verification (WIDTH=8)
REQ-029 a=0x5A, b=0x3C, cin=0, start pulse -> done 8 edges later, sum=0x96, cout=0, ovf=1 (with macro).
REQ-030 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1, ovf=0.
REQ-031 start=1 held continuously with operand sets (0x01,0x01,0) then (0x80,0x80,0) -> done pulses 9 cycles apart, sums 0x02 then 0x00, cout 0 then 1, ovf 0 then 1.
REQ-032 start re-pulsed with a=0x00,b=0x00 during RUN of 0x10+0x20 -> ignored; result 0x30, single done.
REQ-033 rst asserted asynchronously at bit 4 of 0x7F+0x01 -> all outputs 0 immediately, no done; next start 0x03+0x04 -> sum=0x07.
REQ-034 Bench SHALL compare every done against a+b+cin reference for 1000 random operand sets, both with and without SERIAL_ADDER_OVF_EN.
